// File: rtl/conv_bin_bcd_pkg.sv
// Shared definitions for the binary-to-BCD display path: digit width, blank code
// understood by the cb7s decoders, and the converter FSM encoding.
package conv_bin_bcd_pkg;

    localparam int         DIGIT_W    = 4;
    localparam logic [3:0] BLANK_CODE = 4'd10;

    typedef logic [1:0] estado_t;

    localparam estado_t IDLE   = 2'd0;
    localparam estado_t SHIFT  = 2'd1;
    localparam estado_t FINISH = 2'd2;

endpackage

// File: rtl/conv_bin_bcd_ajuste_add3.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets 3 added so that
// the following left shift carries correctly into the next decade.
module ajuste_add3
    import conv_bin_bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] digito,
    output logic [DIGIT_W-1:0] ajustado
);

    always_comb begin
        ajustado = digito;
        if (digito >= 4'd5) begin
            ajustado = digito + 4'd3;
        end
    end

endmodule

// File: rtl/conv_bin_bcd.sv
// Sequential binary-to-BCD converter for the cb7s displays: one shift per cycle,
// digits registered and only updated once a conversion has fully completed.
module conv_bin_bcd
    import conv_bin_bcd_pkg::*;
#(
    parameter int WIDTH  = 10,
    parameter int DIGITS = 4
)
(
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [WIDTH-1:0]            valor,
    input  logic                        blank_zeros,
    output logic [DIGIT_W*DIGITS-1:0]   digitos,
    output logic                        busy,
    output logic                        pronto
);

    localparam int ACC_W = DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] ULTIMO = CNT_W'(WIDTH - 1);

    if (2**WIDTH - 1 >= 10**DIGITS) begin : g_chk_digits
        $error("conv_bin_bcd: DIGITS too small for WIDTH");
    end

    estado_t           estado;
    logic [WIDTH-1:0]  shreg;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_aj;
    logic [ACC_W-1:0]  acc_blk;
    logic [CNT_W-1:0]  cnt;
    logic              blank_lat;
    logic              lead;

    for (genvar g = 0; g < DIGITS; g++) begin : g_aj
        ajuste_add3 u_aj (
            .digito   (acc[g*DIGIT_W +: DIGIT_W]),
            .ajustado (acc_aj[g*DIGIT_W +: DIGIT_W])
        );
    end

    // Leading-zero blanking, MSD downwards; digit 0 always shown.
    always_comb begin
        acc_blk = acc;
        lead    = blank_lat;
        for (int unsigned i = DIGITS - 1; i >= 1; i--) begin
            if (lead && acc[i*DIGIT_W +: DIGIT_W] == 4'd0) begin
                acc_blk[i*DIGIT_W +: DIGIT_W] = BLANK_CODE;
            end else begin
                lead = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado    <= IDLE;
            digitos   <= {DIGITS{BLANK_CODE}};
            pronto    <= 1'b0;
            shreg     <= '0;
            acc       <= '0;
            cnt       <= '0;
            blank_lat <= 1'b0;
        end else begin
            pronto <= 1'b0;
            case (estado)
                IDLE: begin
                    if (start) begin
                        shreg     <= valor;
                        acc       <= '0;
                        cnt       <= '0;
                        blank_lat <= blank_zeros;
                        estado    <= SHIFT;
                    end
                end
                SHIFT: begin
                    {acc, shreg} <= {acc_aj, shreg} << 1;
                    cnt          <= cnt + 1'b1;
                    if (cnt == ULTIMO) begin
                        estado <= FINISH;
                    end
                end
                FINISH: begin
                    digitos <= acc_blk;
                    pronto  <= 1'b1;
                    estado  <= IDLE;
                end
                default: estado <= IDLE;
            endcase
        end
    end

    assign busy = (estado != IDLE);

endmodule
